// File: rtl/dyn_console_s02_if.sv
// Host command bus for the text console VRAM stage: valid/ready command handshake
// plus the registered cursor address reported back to the host.
interface dyn_console_s02_if;
   logic        host_valid;
   logic        host_ready;
   logic [1:0]  host_cmd;
   logic [7:0]  host_data;
   logic [12:0] cursor_addr;

   modport master (
      output host_valid,
      output host_cmd,
      output host_data,
      input  host_ready,
      input  cursor_addr
   );

   modport slave (
      input  host_valid,
      input  host_cmd,
      input  host_data,
      output host_ready,
      output cursor_addr
   );
endinterface

// File: rtl/dyn_console_s02.sv
// Text console stage 02: character VRAM with a host command FSM and a 1-cycle pixel read path.
// Optional blinking cursor overlay is built only when DYNCONSOLE_CURSOR_EN is defined.
module dyn_console_s02 #(
   parameter int unsigned size  = 16,
   parameter int unsigned cols  = 40,
   parameter int unsigned rows  = 30,
   parameter int unsigned depth = 1200,
   localparam int unsigned pS   = $clog2(size)
) (
   input  logic          px_clk,
   input  logic          reset,
   input  logic [25:0]   RGBStr_i,
   input  logic [12:0]   addr_vram_i,
   input  logic [9:0]    pos_x_i,
   input  logic [9:0]    pos_y_i,
   output logic [25:0]   RGBStr_o,
   output logic [7:0]    char_code,
   output logic [pS-1:0] glyph_x,
   output logic [pS-1:0] glyph_y,
   output logic          cursor_hit,
   dyn_console_s02_if.slave host
);

   localparam int unsigned AW = $clog2(depth);
   localparam int unsigned CW = $clog2(cols);
   localparam int unsigned RW = $clog2(rows);
   localparam logic [12:0] ColsW  = 13'(cols);
   localparam logic [12:0] DepthW = 13'(depth);
   localparam logic [CW-1:0] ColMax = CW'(cols - 1);
   localparam logic [RW-1:0] RowMax = RW'(rows - 1);
   localparam logic [AW-1:0] PtrMax = AW'(depth - 1);
   localparam logic [7:0] ChSpace   = 8'h20;
   localparam logic [7:0] ChNewline = 8'h0A;

   typedef enum logic [0:0] {StClear, StIdle} state_e;
   typedef enum logic [1:0] {CmdPutc = 2'b00, CmdSetCol = 2'b01,
                             CmdSetRow = 2'b10, CmdClear = 2'b11} cmd_e;

   state_e        state_q, state_d;
   logic [AW-1:0] clr_ptr_q, clr_ptr_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [12:0]   cursor_addr_q;

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;

   logic [7:0]    vram [depth];

   logic          unused_pos;
   assign unused_pos = ^{pos_x_i[9:pS], pos_y_i[9:pS]};

   assign host.host_ready  = (state_q == StIdle);
   assign host.cursor_addr = cursor_addr_q;

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      col_d     = col_q;
      row_d     = row_q;
      wr_en     = 1'b0;
      wr_addr   = clr_ptr_q;
      wr_data   = ChSpace;
      unique case (state_q)
         StClear: begin
            wr_en     = 1'b1;
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == PtrMax) begin
               state_d   = StIdle;
               clr_ptr_d = '0;
               col_d     = '0;
               row_d     = '0;
            end
         end
         StIdle: begin
            if (host.host_valid) begin
               unique case (cmd_e'(host.host_cmd))
                  CmdPutc: begin
                     if (host.host_data != ChNewline) begin
                        wr_en   = 1'b1;
                        wr_addr = cursor_addr_q[AW-1:0];
                        wr_data = host.host_data;
                     end
                     // Newline and end-of-line both start the next row; no scrolling.
                     if (host.host_data == ChNewline || col_q == ColMax) begin
                        col_d = '0;
                        row_d = (row_q == RowMax) ? '0 : row_q + 1'b1;
                     end else begin
                        col_d = col_q + 1'b1;
                     end
                  end
                  CmdSetCol: begin
                     col_d = (32'(host.host_data) > cols - 1) ? ColMax : CW'(host.host_data);
                  end
                  CmdSetRow: begin
                     row_d = (32'(host.host_data) > rows - 1) ? RowMax : RW'(host.host_data);
                  end
                  CmdClear: begin
                     state_d   = StClear;
                     clr_ptr_d = '0;
                  end
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge px_clk or posedge reset) begin
      if (reset) begin
         state_q       <= StClear;
         clr_ptr_q     <= '0;
         col_q         <= '0;
         row_q         <= '0;
         cursor_addr_q <= '0;
      end else begin
         state_q       <= state_d;
         clr_ptr_q     <= clr_ptr_d;
         col_q         <= col_d;
         row_q         <= row_d;
         // Built from next-state so the write address is valid for back-to-back PUTC.
         cursor_addr_q <= 13'(row_d) * ColsW + 13'(col_d);
      end
   end

   always_ff @(posedge px_clk) begin
      if (wr_en) begin
         vram[wr_addr] <= wr_data;
      end
   end

   // Nonblocking write above makes a same-address read return the old data.
   always_ff @(posedge px_clk or posedge reset) begin
      if (reset) begin
         RGBStr_o  <= '0;
         char_code <= 8'h00;
         glyph_x   <= '0;
         glyph_y   <= '0;
      end else begin
         RGBStr_o  <= RGBStr_i;
         char_code <= (addr_vram_i < DepthW) ? vram[addr_vram_i[AW-1:0]] : ChSpace;
         glyph_x   <= RGBStr_i[13 +: pS] - pos_x_i[pS-1:0];
         glyph_y   <= RGBStr_i[3 +: pS] - pos_y_i[pS-1:0];
      end
   end

`ifdef DYNCONSOLE_CURSOR_EN
   logic       vs_q;
   logic [4:0] frame_q;
   logic       blink_q;

   always_ff @(posedge px_clk or posedge reset) begin
      if (reset) begin
         vs_q       <= 1'b0;
         frame_q    <= '0;
         blink_q    <= 1'b1;
         cursor_hit <= 1'b0;
      end else begin
         vs_q <= RGBStr_i[1];
         if (RGBStr_i[1] && !vs_q) begin
            frame_q <= frame_q + 1'b1;
            if (frame_q == 5'd31) begin
               blink_q <= ~blink_q;
            end
         end
         cursor_hit <= RGBStr_i[0] & blink_q & (addr_vram_i == cursor_addr_q);
      end
   end
`else
   assign cursor_hit = 1'b0;
`endif

endmodule

// File: tb/tb_dyn_console_s02.sv
// Self-checking bench for dyn_console_s02: random pixel reads and host commands against
// a linear-index console model; blink checks follow DYNCONSOLE_CURSOR_EN.
module tb_dyn_console_s02;

   logic        px_clk = 1'b0;
   logic        reset;
   logic [25:0] rgb_in;
   logic [12:0] addr;
   logic [9:0]  pos_x, pos_y;
   logic [25:0] rgb_out;
   logic [7:0]  char_code;
   logic [3:0]  glyph_x, glyph_y;
   logic        cursor_hit;

   dyn_console_s02_if hbus();

   dyn_console_s02 dut (
      .px_clk     (px_clk),
      .reset      (reset),
      .RGBStr_i   (rgb_in),
      .addr_vram_i(addr),
      .pos_x_i    (pos_x),
      .pos_y_i    (pos_y),
      .RGBStr_o   (rgb_out),
      .char_code  (char_code),
      .glyph_x    (glyph_x),
      .glyph_y    (glyph_y),
      .cursor_hit (cursor_hit),
      .host       (hbus)
   );

   always #5 px_clk = ~px_clk;

   int checks = 0;
   int errors = 0;

   // Model: screen as a flat array, cursor as a linear cell index.
   logic [7:0] ref_vram [1200];
   int ref_idx = 0;
   int ref_frames = 0;
   bit ref_blink = 1'b1;

   task automatic tick();
      @(posedge px_clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 1200; i++) ref_vram[i] = 8'h20;
      ref_idx = 0;
   endtask

   task automatic drive_pix(input int a, input int x, input int y, input int px, input int py,
                            input bit act, input bit vs);
      addr   = 13'(a);
      pos_x  = 10'(px);
      pos_y  = 10'(py);
      rgb_in = {3'($urandom), 10'(x), 10'(y), 1'($urandom), vs, act};
   endtask

   task automatic check_pix(input int a, input int x, input int y, input int px, input int py,
                            input bit act, input string tag);
      logic [25:0] sent;
      logic [7:0]  exp_c;
      logic [3:0]  exp_gx, exp_gy;
      logic        exp_hit;
      drive_pix(a, x, y, px, py, act, 1'b0);
      sent    = rgb_in;
      exp_c   = (a < 1200) ? ref_vram[a] : 8'h20;
      exp_gx  = 4'(((x % 16) - (px % 16) + 16) % 16);
      exp_gy  = 4'(((y % 16) - (py % 16) + 16) % 16);
      exp_hit = 1'b0;
`ifdef DYNCONSOLE_CURSOR_EN
      exp_hit = act && (a == ref_idx) && ref_blink;
`endif
      tick();
      checks += 5;
      if (char_code !== exp_c) begin
         errors++;
         $display("FAIL %s char addr=%0d got %h want %h", tag, a, char_code, exp_c);
      end
      if (rgb_out !== sent) begin
         errors++;
         $display("FAIL %s rgb_delay got %h want %h", tag, rgb_out, sent);
      end
      if (glyph_x !== exp_gx) begin
         errors++;
         $display("FAIL %s glyph_x got %0d want %0d", tag, glyph_x, exp_gx);
      end
      if (glyph_y !== exp_gy) begin
         errors++;
         $display("FAIL %s glyph_y got %0d want %0d", tag, glyph_y, exp_gy);
      end
      if (cursor_hit !== exp_hit) begin
         errors++;
         $display("FAIL %s cursor_hit got %b want %b", tag, cursor_hit, exp_hit);
      end
   endtask

   task automatic check_rand_pix(input int a, input string tag);
      check_pix(a, $urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 639),
                $urandom_range(0, 479), 1'($urandom), tag);
   endtask

   task automatic check_cursor(input int want, input string tag);
      checks++;
      if (hbus.cursor_addr !== 13'(want)) begin
         errors++;
         $display("FAIL %s cursor_addr got %0d want %0d", tag, hbus.cursor_addr, want);
      end
   endtask

   task automatic send_cmd(input int cmd, input int d);
      int cnt = 0;
      hbus.host_valid = 1'b1;
      hbus.host_cmd   = 2'(cmd);
      hbus.host_data  = 8'(d);
      while (!hbus.host_ready && cnt < 3000) begin
         tick();
         cnt++;
      end
      if (cnt >= 3000) begin
         checks++;
         errors++;
         $display("FAIL send_cmd host_ready got 0 want 1 within 3000 cycles");
      end
      tick();
      hbus.host_valid = 1'b0;
      case (cmd)
         0: if (d == 8'h0A) ref_idx = ((ref_idx / 40 + 1) % 30) * 40;
            else begin
               ref_vram[ref_idx] = 8'(d);
               ref_idx = (ref_idx + 1) % 1200;
            end
         1: ref_idx = (ref_idx / 40) * 40 + ((d > 39) ? 39 : d);
         2: ref_idx = ((d > 29) ? 29 : d) * 40 + ref_idx % 40;
         default: ;
      endcase
   endtask

   task automatic wait_clear(input string tag);
      int cnt = 0;
      while (!hbus.host_ready && cnt < 2000) begin
         tick();
         cnt++;
      end
      hbus.host_valid = 1'b0;
      checks++;
      if (cnt != 1200) begin
         errors++;
         $display("FAIL %s clear_cycles got %0d want 1200", tag, cnt);
      end
      model_clear();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      hbus.host_valid = 1'b1;
      hbus.host_cmd   = 2'b00;
      hbus.host_data  = 8'h55;
      addr = '0; pos_x = '0; pos_y = '0; rgb_in = '0;
      #12;
      checks += 6;
      if (hbus.host_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", hbus.host_ready); end
      if (hbus.cursor_addr !== 13'd0) begin errors++; $display("FAIL rst_cursor got %0d want 0", hbus.cursor_addr); end
      if (char_code !== 8'h00) begin errors++; $display("FAIL rst_char got %h want 00", char_code); end
      if (rgb_out !== 26'd0) begin errors++; $display("FAIL rst_rgb got %h want 0", rgb_out); end
      if (glyph_x !== 4'd0 || glyph_y !== 4'd0) begin
         errors++; $display("FAIL rst_glyph got %0d/%0d want 0/0", glyph_x, glyph_y);
      end
      if (cursor_hit !== 1'b0) begin errors++; $display("FAIL rst_hit got %b want 0", cursor_hit); end
      tick();
      reset = 1'b0;
      repeat (500) tick();
      checks++;
      if (hbus.host_ready !== 1'b0) begin errors++; $display("FAIL midclear_ready got %b want 0", hbus.host_ready); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wait_clear("reset_clear");
   endtask

   task automatic test_clear_contents();
      int bad = 0;
      for (int a = 0; a < 1200; a++) begin
         addr = 13'(a);
         tick();
         if (char_code !== 8'h20) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL clear_contents bad_cells got %0d want 0", bad); end
      check_cursor(0, "clear_cursor");
   endtask

   task automatic test_putc();
      send_cmd(0, 8'h41);
      tick();
      check_cursor(1, "putc_cursor");
      check_rand_pix(0, "putc_read");
   endtask

   task automatic test_wrap();
      send_cmd(2, 29);
      send_cmd(1, 39);
      send_cmd(0, 8'h42);
      check_cursor(0, "wrap_cursor");
      check_rand_pix(1199, "wrap_read");
      send_cmd(1, 200);
      check_cursor(39, "col_clamp");
      send_cmd(2, 200);
      check_cursor(1199, "row_clamp");
   endtask

   task automatic test_newline();
      send_cmd(2, 3);
      send_cmd(1, 5);
      send_cmd(0, 8'h0A);
      check_cursor(160, "newline_cursor");
      check_rand_pix(125, "newline_nowrite");
      check_rand_pix(1500, "oob_1500");
      check_rand_pix(8191, "oob_8191");
   endtask

   task automatic test_read_first();
      send_cmd(2, 0);
      send_cmd(1, 10);
      hbus.host_valid = 1'b1;
      hbus.host_cmd   = 2'b00;
      hbus.host_data  = 8'h43;
      addr = 13'd10;
      tick();
      hbus.host_valid = 1'b0;
      checks++;
      if (char_code !== 8'h20) begin errors++; $display("FAIL read_first got %h want 20", char_code); end
      ref_vram[10] = 8'h43;
      ref_idx = 11;
      check_rand_pix(10, "read_after_write");
      check_pix(5, 37, 50, 32, 48, 1'b0, "glyph_37_32");
   endtask

   task automatic test_back_to_back();
      int start = ref_idx;
      for (int i = 0; i < 6; i++) send_cmd(0, 8'h60 + i);
      for (int i = 0; i < 6; i++) check_rand_pix((start + i) % 1200, "b2b_read");
      check_cursor(ref_idx, "b2b_cursor");
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         int r = $urandom_range(0, 9);
         if (r < 4) send_cmd(0, ($urandom_range(0, 7) == 0) ? 8'h0A : $urandom_range(0, 255));
         else if (r == 4) send_cmd(1, $urandom_range(0, 63));
         else if (r == 5) send_cmd(2, $urandom_range(0, 40));
         else if (r == 6) check_rand_pix((ref_idx + 1199) % 1200, "rand_recent");
         else check_rand_pix($urandom_range(0, 1300), "rand_read");
      end
      check_cursor(ref_idx, "rand_cursor");
   endtask

   task automatic test_clear_cmd();
      send_cmd(3, 0);
      checks++;
      if (hbus.host_ready !== 1'b0) begin errors++; $display("FAIL clear_cmd_ready got %b want 0", hbus.host_ready); end
      wait_clear("clear_cmd");
      check_cursor(0, "clear_cmd_cursor");
      check_rand_pix(10, "clear_cmd_read10");
      check_rand_pix(0, "clear_cmd_read0");
   endtask

   task automatic vs_pulse();
      drive_pix(0, 0, 0, 0, 0, 1'b0, 1'b1);
      tick();
      drive_pix(0, 0, 0, 0, 0, 1'b0, 1'b0);
      tick();
      ref_frames++;
      ref_blink = ((ref_frames / 32) % 2) == 0;
   endtask

   task automatic test_cursor();
      send_cmd(2, 0);
      send_cmd(1, 7);
      check_pix(7, 100, 100, 96, 96, 1'b1, "cursor_frame0");
      check_pix(7, 100, 100, 96, 96, 1'b0, "cursor_inactive");
      check_pix(8, 100, 100, 96, 96, 1'b1, "cursor_other_cell");
      repeat (31) vs_pulse();
      check_pix(7, 100, 100, 96, 96, 1'b1, "cursor_frame31");
      vs_pulse();
      check_pix(7, 100, 100, 96, 96, 1'b1, "cursor_frame32");
      repeat (31) vs_pulse();
      check_pix(7, 100, 100, 96, 96, 1'b1, "cursor_frame63");
      vs_pulse();
      check_pix(7, 100, 100, 96, 96, 1'b1, "cursor_frame64");
   endtask

   initial begin
      hbus.host_valid = 1'b0;
      hbus.host_cmd   = 2'b00;
      hbus.host_data  = 8'h00;
      test_reset();
      test_clear_contents();
      test_putc();
      test_wrap();
      test_newline();
      test_read_first();
      test_back_to_back();
      test_random();
      test_clear_cmd();
      test_cursor();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
